// File: rtl/mac_cfg_master.sv
// Bus initiator that acquires a MAC accelerator context, programs one job, triggers it and polls STATUS.
// Optional build macro MAC_CFG_MASTER_READBACK_EN adds a read-back check of the job registers before TRIGGER.
module mac_cfg_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ID_WIDTH  = 10,
    parameter int          RETRY_GAP = 4,
    parameter int          POLL_GAP  = 8,
    parameter int          POLL_MAX  = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [7:0][31:0]      job_i,
    output logic                  done_o,
    output logic                  error_o,
    output logic [7:0]            job_id_o,
    output logic                  req_o,
    output logic [31:0]           add_o,
    output logic                  wen_o,
    output logic [3:0]            be_o,
    output logic [31:0]           data_o,
    output logic [ID_WIDTH-1:0]   id_o,
    input  logic                  gnt_i,
    input  logic                  r_valid_i,
    input  logic [31:0]           r_data_i,
    input  logic [ID_WIDTH-1:0]   r_id_i
);

    localparam logic [31:0] OFS_TRIGGER = 32'h00;
    localparam logic [31:0] OFS_ACQUIRE = 32'h04;
    localparam logic [31:0] OFS_STATUS  = 32'h0C;
    localparam logic [31:0] OFS_JOB     = 32'h40;
    localparam logic [31:0] ACQ_BUSY    = 32'hFFFF_FFFF;
    localparam logic [15:0] RETRY_LAST  = 16'(RETRY_GAP - 1);
    localparam logic [15:0] POLL_LAST   = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT  = 16'(POLL_MAX);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACQ,
        S_ACQ_RSP,
        S_ACQ_WAIT,
        S_CFG,
        S_CFG_RSP,
`ifdef MAC_CFG_MASTER_READBACK_EN
        S_VFY,
        S_VFY_RSP,
`endif
        S_TRIG,
        S_TRIG_RSP,
        S_POLL_WAIT,
        S_POLL,
        S_POLL_RSP,
        S_DONE
    } state_t;

    state_t              state;
    logic [7:0][31:0]    desc;
    logic [2:0]          idx;
    logic [15:0]         gap_cnt;
    logic [15:0]         poll_cnt;
    logic [ID_WIDTH-1:0] last_id;
    logic                rsp_bad;

    assign be_o    = 4'hF;
    assign rsp_bad = (r_id_i != last_id);

    function automatic logic [31:0] job_addr(input logic [2:0] k);
        return BASE_ADDR + OFS_JOB + {27'd0, k, 2'b00};
    endfunction

    // Request fields are only loaded here, so they hold still while the grant is pending.
    task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wdata);
        req_o  <= 1'b1;
        add_o  <= addr;
        wen_o  <= rd;
        data_o <= wdata;
    endtask

    task automatic finish(input logic err);
        done_o  <= 1'b1;
        error_o <= err;
        state   <= S_DONE;
    endtask

    // Descriptor is pure data: captured on acceptance, never reset.
    always_ff @(posedge clk_i) begin
        if (state == S_IDLE && job_valid_i) begin
            desc <= job_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            job_ready_o <= 1'b1;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            job_id_o    <= '0;
            req_o       <= 1'b0;
            add_o       <= '0;
            wen_o       <= 1'b0;
            data_o      <= '0;
            id_o        <= '0;
            last_id     <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
        end else begin
            if (req_o && gnt_i) begin
                req_o   <= 1'b0;
                last_id <= id_o;
                id_o    <= id_o + ID_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (job_valid_i) begin
                        job_ready_o <= 1'b0;
                        job_id_o    <= '0;
                        poll_cnt    <= '0;
                        issue(BASE_ADDR + OFS_ACQUIRE, 1'b1, 32'd0);
                        state       <= S_ACQ;
                    end
                end

                S_ACQ: if (gnt_i) state <= S_ACQ_RSP;

                S_ACQ_RSP: begin
                    if (r_valid_i) begin
                        if (rsp_bad) begin
                            finish(1'b1);
                        end else if (r_data_i == ACQ_BUSY) begin
                            gap_cnt <= '0;
                            state   <= S_ACQ_WAIT;
                        end else begin
                            job_id_o <= r_data_i[7:0];
                            idx      <= '0;
                            issue(job_addr(3'd0), 1'b0, desc[0]);
                            state    <= S_CFG;
                        end
                    end
                end

                S_ACQ_WAIT: begin
                    if (gap_cnt == RETRY_LAST) begin
                        issue(BASE_ADDR + OFS_ACQUIRE, 1'b1, 32'd0);
                        state <= S_ACQ;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                S_CFG: if (gnt_i) state <= S_CFG_RSP;

                S_CFG_RSP: begin
                    if (r_valid_i) begin
                        if (rsp_bad) begin
                            finish(1'b1);
                        end else if (idx == 3'd7) begin
`ifdef MAC_CFG_MASTER_READBACK_EN
                            idx   <= '0;
                            issue(job_addr(3'd0), 1'b1, 32'd0);
                            state <= S_VFY;
`else
                            issue(BASE_ADDR + OFS_TRIGGER, 1'b0, 32'd0);
                            state <= S_TRIG;
`endif
                        end else begin
                            idx   <= idx + 3'd1;
                            issue(job_addr(idx + 3'd1), 1'b0, desc[idx + 3'd1]);
                            state <= S_CFG;
                        end
                    end
                end

`ifdef MAC_CFG_MASTER_READBACK_EN
                S_VFY: if (gnt_i) state <= S_VFY_RSP;

                // A register that reads back differently means the job must never be triggered.
                S_VFY_RSP: begin
                    if (r_valid_i) begin
                        if (rsp_bad || r_data_i != desc[idx]) begin
                            finish(1'b1);
                        end else if (idx == 3'd7) begin
                            issue(BASE_ADDR + OFS_TRIGGER, 1'b0, 32'd0);
                            state <= S_TRIG;
                        end else begin
                            idx   <= idx + 3'd1;
                            issue(job_addr(idx + 3'd1), 1'b1, 32'd0);
                            state <= S_VFY;
                        end
                    end
                end
`endif

                S_TRIG: if (gnt_i) state <= S_TRIG_RSP;

                S_TRIG_RSP: begin
                    if (r_valid_i) begin
                        if (rsp_bad) begin
                            finish(1'b1);
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_POLL_WAIT;
                        end
                    end
                end

                S_POLL_WAIT: begin
                    if (gap_cnt == POLL_LAST) begin
                        issue(BASE_ADDR + OFS_STATUS, 1'b1, 32'd0);
                        state <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                S_POLL: if (gnt_i) state <= S_POLL_RSP;

                // The poll that brings the count to POLL_MAX is the last one allowed.
                S_POLL_RSP: begin
                    if (r_valid_i) begin
                        if (rsp_bad) begin
                            finish(1'b1);
                        end else if (r_data_i == 32'd0) begin
                            finish(1'b0);
                        end else if (poll_cnt + 16'd1 == POLL_LIMIT) begin
                            finish(1'b1);
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                            gap_cnt  <= '0;
                            state    <= S_POLL_WAIT;
                        end
                    end
                end

                S_DONE: begin
                    done_o      <= 1'b0;
                    error_o     <= 1'b0;
                    job_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_cfg_master.sv
// Scoreboard bench for mac_cfg_master: a negedge bus slave model plus a done_o monitor fed by an expectation queue.
`timescale 1ns/1ps
module tb_mac_cfg_master;
    localparam int IDW = 10;
`ifdef MAC_CFG_MASTER_READBACK_EN
    localparam int EXP_LAT = 46;
`else
    localparam int EXP_LAT = 30;
`endif

    logic             clk = 1'b0;
    logic             rst_i, job_valid_i, job_ready_o, done_o, error_o;
    logic [7:0][31:0] job_i;
    logic [7:0]       job_id_o;
    logic             req_o, wen_o, gnt_i, r_valid_i;
    logic [31:0]      add_o, data_o, r_data_i;
    logic [3:0]       be_o;
    logic [IDW-1:0]   id_o, r_id_i;

    always #5 clk = ~clk;

    mac_cfg_master #(
        .BASE_ADDR(32'h0000_0000), .ID_WIDTH(IDW), .RETRY_GAP(4), .POLL_GAP(8), .POLL_MAX(3)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_i(job_i), .done_o(done_o), .error_o(error_o), .job_id_o(job_id_o),
        .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .be_o(be_o), .data_o(data_o), .id_o(id_o),
        .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_id_i(r_id_i)
    );

    typedef struct { logic err; logic [7:0] jid; int lat; } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0, cyc = 0, submit_cyc = 0, ndone = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave model state
    logic [31:0]    acq_q[$];
    logic [31:0]    wlog[$];
    int             acq_gnt_cyc[$];
    logic [31:0]    mem[8];
    bit             status_nz = 0, pend = 0, force_rv = 0, snap_ok = 0;
    logic [31:0]    stall_addr = 32'hFFFF_FFFF, bad_addr = 32'hFFFF_FFFF;
    int             stall_left = 0, n_status = 0, n_trig = 0, n_48 = 0;
    logic [IDW-1:0] exp_id = '0, pend_id;
    logic [31:0]    pend_data;
    logic [74:0]    snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus slave: grants on the negedge, answers one cycle after the grant edge.
    initial begin
        gnt_i = 0; r_valid_i = 0; r_data_i = 0; r_id_i = 0;
        forever begin
            @(negedge clk);
            r_valid_i = 0;
            gnt_i     = 0;
            if (pend) begin
                r_valid_i = 1; r_data_i = pend_data; r_id_i = pend_id; pend = 0;
            end else if (force_rv) begin
                r_valid_i = 1; r_data_i = 32'h1234; r_id_i = id_o; force_rv = 0;
            end
            if (req_o === 1'b1) begin
                if (add_o == stall_addr && stall_left > 0) begin
                    if (!snap_ok) begin
                        snap = {add_o, wen_o, data_o, id_o}; snap_ok = 1;
                    end else begin
                        check("stall_fields", 32'({add_o, wen_o, data_o, id_o} == snap), 1);
                    end
                    stall_left--;
                end else begin
                    gnt_i = 1;
                    if (snap_ok) begin
                        check("stall_fields_at_grant", 32'({add_o, wen_o, data_o, id_o} == snap), 1);
                        snap_ok = 0;
                    end
                    check("be", be_o, 4'hF);
                    check("id_seq", id_o, exp_id);
                    exp_id  = id_o + IDW'(1);
                    pend_id = (add_o == bad_addr) ? id_o + IDW'(7) : id_o;
                    pend    = 1;
                    if (!wen_o) begin
                        wlog.push_back(add_o);
                        if (add_o >= 32'h40 && add_o < 32'h60) mem[add_o[4:2]] = data_o;
                        if (add_o == 32'h0) n_trig++;
                        if (add_o == 32'h48) n_48++;
                        pend_data = 0;
                    end else if (add_o == 32'h4) begin
                        acq_gnt_cyc.push_back(cyc);
                        pend_data = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
                    end else if (add_o == 32'hC) begin
                        n_status++;
                        pend_data = status_nz ? 32'h1 : 32'h0;
                    end else begin
                        pend_data = (add_o >= 32'h40 && add_o < 32'h60) ? mem[add_o[4:2]] : 32'h0;
                    end
                end
            end
        end
    end

    // Completion monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("error", error_o, e.err);
                    check("job_id", job_id_o, e.jid);
                    if (e.lat != 0) check("latency", cyc - submit_cyc, e.lat);
                end
                ndone++;
            end
        end
    end

    task automatic run_job(input logic e, input logic [7:0] jid, input int lat);
        int start;
        bit got;
        @(negedge clk);
        check("ready_before_job", job_ready_o, 1);
        exp_q.push_back('{e, jid, lat});
        start       = ndone;
        submit_cyc  = cyc + 1;
        job_valid_i = 1;
        @(negedge clk);
        job_valid_i = 0;
        check("req_after_accept", req_o, 1);
        check("busy_after_accept", job_ready_o, 0);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = (ndone != start);
        end
        check("done_seen", 32'(got), 1);
        if (!got) exp_q.delete();
    endtask

    initial begin
        bit got;
        rst_i = 1; job_valid_i = 0;
        for (int k = 0; k < 8; k++) job_i[k] = 32'hA000_0000 + k * 32'h0101_0011;
        repeat (3) @(negedge clk);
        check("rst_job_ready", job_ready_o, 1);
        check("rst_req", req_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_id", id_o, 0);
        check("rst_be", be_o, 4'hF);
        rst_i = 0;

        // ideal slave
        wlog.delete(); acq_q.push_back(32'h3);
        run_job(0, 8'h3, EXP_LAT);
        check("wlog_size", wlog.size(), 9);
        for (int k = 0; k < 8; k++) check("cfg_write_addr", wlog[k], 32'h40 + 4 * k);
        check("trigger_write_addr", wlog[8], 32'h0);

        // ACQUIRE busy twice
        acq_gnt_cyc.delete();
        acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'h1);
        run_job(0, 8'h1, 0);
        check("acq_reads", acq_gnt_cyc.size(), 3);
        check("acq_gap_1", acq_gnt_cyc[1] - acq_gnt_cyc[0], 6);
        check("acq_gap_2", acq_gnt_cyc[2] - acq_gnt_cyc[1], 6);

        // grant withheld on write to 0x48
        acq_q.push_back(32'h2); n_48 = 0; stall_addr = 32'h48; stall_left = 5;
        run_job(0, 8'h2, 0);
        check("stall_grants_0x48", n_48, 1);
        check("stall_consumed", stall_left, 0);
        stall_addr = 32'hFFFF_FFFF;

        // STATUS never clears
        acq_q.push_back(32'h5); status_nz = 1; n_status = 0;
        run_job(1, 8'h5, 0);
        check("status_polls", n_status, 3);
        status_nz = 0;

        // wrong response ID during CFG
        acq_q.push_back(32'h6); bad_addr = 32'h48; n_trig = 0;
        run_job(1, 8'h6, 0);
        check("no_trigger_after_bad_id", n_trig, 0);
        bad_addr = 32'hFFFF_FFFF;

        // reset while waiting between polls
        acq_q.push_back(32'h2); n_trig = 0;
        @(negedge clk); job_valid_i = 1;
        @(negedge clk); job_valid_i = 0;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (n_trig != 0);
        end
        check("trigger_before_reset", n_trig, 1);
        repeat (3) @(negedge clk);
        rst_i = 1; exp_id = '0;
        @(negedge clk);
        rst_i = 0;
        check("post_rst_req", req_o, 0);
        check("post_rst_ready", job_ready_o, 1);
        check("post_rst_done", done_o, 0);
        force_rv = 1;
        repeat (20) @(negedge clk);
        check("late_rsp_ready", job_ready_o, 1);
        check("late_rsp_req", req_o, 0);

        // recovery job after reset
        acq_q.push_back(32'h7);
        run_job(0, 8'h7, EXP_LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
